// File: rtl/pulse_generator.sv
// Turns one-cycle request pulses into shaped output pulses of programmable high width and low gap.
// Requests that arrive during a pulse are queued in a saturating counter with a sticky overflow flag.
module pulse_generator #(
  parameter int CNT_W  = 8,
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              clear,
  input  logic [CNT_W-1:0]  high_len,
  input  logic [CNT_W-1:0]  gap_len,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [CNT_W-1:0]   hl_r, hl_s;
  logic [CNT_W-1:0]   gl_r, gl_s;
  logic [PEND_W-1:0]  pend_r, pend_s;
  logic               ovf_r, ovf_s;
  logic               out_r, out_s;
  logic               done_r, done_s;
  logic               busy_r, busy_s;
  logic               start_s;
  logic               consume_s;
  logic [CNT_W-1:0]   hl_eff_s;
  logic [CNT_W-1:0]   gl_eff_s;

  assign hl_eff_s = (high_len == {CNT_W{1'b0}}) ? CNT_ONE : high_len;
  assign gl_eff_s = (gap_len  == {CNT_W{1'b0}}) ? CNT_ONE : gap_len;

  // State, phase counter, latched lengths, queue and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      hl_r    <= {CNT_W{1'b0}};
      gl_r    <= {CNT_W{1'b0}};
      pend_r  <= {PEND_W{1'b0}};
      ovf_r   <= 1'b0;
      out_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      hl_r    <= hl_s;
      gl_r    <= gl_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      out_r   <= out_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state, phase counting and pending-queue accounting
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    hl_s      = hl_r;
    gl_s      = gl_r;
    pend_s    = pend_r;
    ovf_s     = ovf_r;
    start_s   = 1'b0;
    consume_s = 1'b0;
    if (clear) begin
      state_s = IDLE;
      cnt_s   = {CNT_W{1'b0}};
      pend_s  = {PEND_W{1'b0}};
      ovf_s   = 1'b0;
    end else begin
      // cnt_r counts elapsed cycles of the current phase, starting at 1
      case (state_r)
        IDLE: begin
          if (trig) begin
            start_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        HIGH: begin
          if (cnt_r == hl_r) begin
            state_s = GAP;
            cnt_s   = CNT_ONE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_r == gl_r) begin
            if ((pend_r != {PEND_W{1'b0}}) || trig) begin
              start_s   = 1'b1;
              consume_s = 1'b1;
            end else begin
              state_s = IDLE;
              cnt_s   = {CNT_W{1'b0}};
            end
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase

      if (start_s) begin
        state_s = HIGH;
        cnt_s   = CNT_ONE;
        hl_s    = hl_eff_s;
        gl_s    = gl_eff_s;
      end else begin
        hl_s = hl_r;
      end

      // A trig from IDLE is consumed by the start itself, so only busy states queue
      if (state_r != IDLE) begin
        if (trig && !consume_s) begin
          if (pend_r == PEND_MAX) begin
            ovf_s = 1'b1;
          end else begin
            pend_s = pend_r + PEND_ONE;
          end
        end else if (consume_s && !trig) begin
          pend_s = pend_r - PEND_ONE;
        end else begin
          pend_s = pend_r;
        end
      end else begin
        pend_s = pend_r;
      end
    end
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    out_s  = (state_s == HIGH);
    done_s = (state_r == HIGH) && (state_s == GAP);
    busy_s = (state_s != IDLE);
  end

  assign out      = out_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign pending  = pend_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_pulse_generator.sv
// Directed and randomized checks of pulse_generator against a timeline-based reference model.
module tb_pulse_generator;

  localparam int CW   = 8;
  localparam int PW   = 2;
  localparam int MAXP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] high_len = '0;
  logic [CW-1:0] gap_len = '0;
  logic          out, busy, done, overflow;
  logic [PW-1:0] pending;

  pulse_generator #(.CNT_W(CW), .PEND_W(PW)) dut (
    .clk(clk), .rst(rst), .trig(trig), .clear(clear),
    .high_len(high_len), .gap_len(gap_len),
    .out(out), .busy(busy), .done(done),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model: a pulse is an interval [m_start, m_start+m_l+m_g) on the edge timeline
  int n = 0;
  bit m_act = 1'b0;
  int m_start = 0, m_l = 0, m_g = 0, m_pend = 0;
  bit m_ovf = 1'b0, m_out = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  int hi_cnt = 0, busy_cnt = 0, done_cnt = 0;

  function automatic int eff(input logic [CW-1:0] x);
    return (x == '0) ? 1 : int'(x);
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_pend = 0; m_ovf = 1'b0;
    m_out = 1'b0; m_done = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_edge();
    int  end_e;
    bit  cons;
    if (clear) begin
      m_act = 1'b0; m_pend = 0; m_ovf = 1'b0;
    end else if (!m_act) begin
      if (trig) begin
        m_act = 1'b1; m_start = n; m_l = eff(high_len); m_g = eff(gap_len);
      end
    end else begin
      end_e = m_start + m_l + m_g;
      cons  = (n == end_e) && (m_pend > 0 || trig);
      if (n == end_e) begin
        if (cons) begin
          m_start = n; m_l = eff(high_len); m_g = eff(gap_len);
        end else begin
          m_act = 1'b0;
        end
      end
      if (trig && !cons) begin
        if (m_pend == MAXP) m_ovf = 1'b1;
        else m_pend++;
      end else if (cons && !trig) begin
        m_pend--;
      end
    end
    m_busy = m_act;
    m_out  = m_act && ((n - m_start) < m_l);
    m_done = m_act && (n == m_start + m_l);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    if (rst) model_reset();
    else model_edge();
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    hi_cnt   += int'(out);
    busy_cnt += int'(busy);
    done_cnt += int'(done);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic set_in(input logic t, input logic c, input int h, input int g);
    trig = t; clear = c; high_len = CW'(h); gap_len = CW'(g);
  endtask

  task automatic zero_counts();
    hi_cnt = 0; busy_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    // Reset held while trig toggles
    set_in(1'b1, 1'b0, 3, 2);
    for (int i = 0; i < 4; i++) begin
      trig = ~trig;
      tick();
    end
    rst = 1'b0;
    set_in(1'b0, 1'b0, 3, 2);
    ticks(3);

    // Single request, high 3 / gap 2
    zero_counts();
    set_in(1'b1, 1'b0, 3, 2);
    tick();
    trig = 1'b0;
    ticks(8);
    chk("single_high_cycles", 32'(hi_cnt), 32'd3);
    chk("single_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("single_done_count", 32'(done_cnt), 32'd1);

    // Zero lengths, two requests
    zero_counts();
    set_in(1'b1, 1'b0, 0, 0);
    ticks(2);
    trig = 1'b0;
    ticks(6);
    chk("zero_high_cycles", 32'(hi_cnt), 32'd2);
    chk("zero_busy_cycles", 32'(busy_cnt), 32'd4);

    // Burst of three, high 2 / gap 1
    zero_counts();
    set_in(1'b1, 1'b0, 2, 1);
    ticks(3);
    trig = 1'b0;
    ticks(10);
    chk("burst_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("burst_high_cycles", 32'(hi_cnt), 32'd6);
    chk("burst_done_count", 32'(done_cnt), 32'd3);

    // Saturation during a long pulse, then clear
    set_in(1'b1, 1'b0, 20, 1);
    ticks(5);
    chk("sat_pending", 32'(pending), 32'd3);
    chk("sat_overflow", 32'(overflow), 32'd1);
    trig = 1'b0;
    ticks(4);
    chk("sat_overflow_sticky", 32'(overflow), 32'd1);
    set_in(1'b1, 1'b1, 20, 1);
    tick();
    set_in(1'b0, 1'b0, 20, 1);
    chk("clear_out", 32'(out), 32'd0);
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_pending", 32'(pending), 32'd0);
    chk("clear_overflow", 32'(overflow), 32'd0);
    ticks(3);

    // Length change mid-pulse affects only the next pulse
    zero_counts();
    set_in(1'b1, 1'b0, 4, 2);
    tick();
    trig = 1'b0;
    tick();
    high_len = CW'(9);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    ticks(20);
    chk("midchange_high_cycles", 32'(hi_cnt), 32'd13);

    // Async reset mid-HIGH with a queued request
    set_in(1'b1, 1'b0, 10, 2);
    tick();
    tick();
    trig = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    ticks(5);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      trig     = ($urandom_range(0, 99) < 35);
      clear    = ($urandom_range(0, 63) == 0);
      high_len = CW'($urandom_range(0, 5));
      gap_len  = CW'($urandom_range(0, 4));
      tick();
    end
    set_in(1'b0, 1'b0, 1, 1);
    ticks(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Converts single-cycle request pulses into timed output pulses of programmable high width, separated by a programmable low gap. It is the counterpart of the team's edge detector, which turns level transitions into one-cycle pulses. This block turns one-cycle pulses back into shaped levels. Requests that arrive while a pulse is in progress are queued in a saturating counter, so no request is lost silently.

## Interface
- CNT_W, 8, width of the length inputs and the internal phase counter
- PEND_W, 4, width of the pending-request counter (max pending = 2^PEND_W-1)

- clk  input  1  clock; all state changes on posedge
- rst  input  1  reset, asynchronous, active-high
- trig  input  1  request; each cycle sampled high is one request
- clear  input  1  synchronous abort/flush
- high_len  input  CNT_W  high-phase length in cycles; 0 treated as 1
- gap_len  input  CNT_W  low-gap length in cycles; 0 treated as 1
- out  output  1  shaped pulse output (registered)
- busy  output  1  high while state is HIGH or GAP
- done  output  1  one-cycle strobe marking the end of each high phase (registered)
- pending  output  PEND_W  queued requests not yet started
- overflow  output  1  sticky; set when a request is dropped because pending is saturated

## Operation
- Reset values: state IDLE, out=0, done=0, busy=0, pending=0, overflow=0. The phase counter and latched lengths are 0.
- Effective lengths: L = max(high_len,1) and G = max(gap_len,1). Both are latched at pulse start. Changes to the inputs mid-pulse do not affect the current pulse.
- IDLE: out=0.
  - trig=1 → latch L and G, go to HIGH, out=1.
  - The request is consumed directly and pending is unchanged.
- HIGH: out=1 for exactly L cycles, then go to GAP with out=0 and done=1 for one cycle.
- GAP: out=0 for exactly G cycles. At the end of the gap:
  - If pending>0 or trig=1 in that cycle: latch new L and G, go to HIGH, and consume one request.
  - Otherwise go to IDLE.
- Pending accounting, in HIGH or GAP:
  - trig without a consume → pending+1.
  - A consume without trig → pending-1.
  - trig and a consume in the same cycle → pending unchanged.
- Saturation: when pending = 2^PEND_W-1, a trig that is not offset by a consume is dropped and overflow is set. Overflow stays set until rst or clear.
- clear (synchronous) has priority over everything in the same cycle:
  - Next state is IDLE, with out=0, done=0, pending=0, overflow=0.
  - A trig in the same cycle is dropped.
- Async rst mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. After release the block stays idle until a new trig.
- The minimum gap of 1 cycle guarantees back-to-back pulses are always separated by at least one low cycle.

## Timing
- If trig is sampled high at edge k from IDLE:
  - out=1 from edge k through edge k+L-1.
  - out falls at edge k+L, and done=1 for the single cycle after edge k+L.
  - The gap occupies edges k+L to k+L+G-1.
  - The next pulse, if queued, rises at edge k+L+G. The pulse period is therefore L+G.
- Latency from trig to out rising: 1 cycle, registered.
- busy rises with out at edge k. It falls at edge k+L+G if nothing is queued.
- pending updates at the same edge that samples trig.

## Test plan
- Reset: hold rst=1 and toggle trig → out=0, busy=0, pending=0, overflow=0 throughout; no pulse after release without a new trig.
- Single request, high_len=3, gap_len=2:
  - out high for exactly 3 cycles starting 1 cycle after trig.
  - done=1 for 1 cycle as out falls.
  - busy high for 5 cycles, then 0.
- Zero lengths, high_len=0 and gap_len=0 → 1-cycle high, then 1-cycle low; two queued requests give the out pattern 1,0,1,0.
- Burst of 3 consecutive trig cycles, high_len=2, gap_len=1:
  - pending goes 0→1→2.
  - Three pulses of 2 high / 1 low (period 3), pending decrementing at each pulse start.
  - busy high for 9 cycles in total.
- Saturation with PEND_W=2: 5 trigs during a long pulse (high_len=20):
  - pending saturates at 3 and overflow sets on the 4th queued trig and stays set.
  - A later clear → pending=0, overflow=0, out=0, state IDLE.
- Mid-pulse events:
  - Change high_len from 4 to 9 during HIGH → the current pulse is still 4 cycles and the next pulse is 9.
  - Assert async rst mid-HIGH → out drops to 0 without a clock edge; pending=0 after release.
